// File: rtl/bram_arbiter_if.sv
// bram_arbiter_if: one requester port of the BRAM arbiter (request, payload, ack, read data)
interface bram_arbiter_if;
  logic        req;
  logic [3:0]  we;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic        ack;
  logic [31:0] rdat;
  modport master(output req, we, adr, wdat, input ack, rdat);
  modport slave(input req, we, adr, wdat, output ack, rdat);
endinterface

// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin two-master sequencer for the single-port user BRAM
// with a fixed DELAYS-cycle access window and a one-cycle ack.
module bram_arbiter #(
  parameter int DELAYS = 10
) (
  input  logic        clk,
  input  logic        rst,
  bram_arbiter_if.slave m0,
  bram_arbiter_if.slave m1,
  output logic        bram_en,
  output logic [3:0]  bram_we,
  output logic [31:0] bram_adr,
  output logic [31:0] bram_di,
  input  logic [31:0] bram_do,
  output logic        busy,
  output logic        grant
);
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d, we_q, we_d;
  logic [31:0] adr_q, adr_d, wdat_q, wdat_d, rdat_q, rdat_d;
  logic        last_q, last_d, grant_q, grant_d, pick;
  always_comb begin
    pick    = (m0.req && m1.req) ? !last_q : m1.req;
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    last_d  = last_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: if (m0.req || m1.req) begin
        state_d = ACCESS;
        cnt_d   = 4'd0;
        grant_d = pick;
        last_d  = pick;
        we_d    = pick ? m1.we : m0.we;
        adr_d   = pick ? m1.adr : m0.adr;
        wdat_d  = pick ? m1.wdat : m0.wdat;
      end
      ACCESS: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(DELAYS - 1)) begin
          rdat_d  = bram_do;
          state_d = ACK;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 4'd0;
      adr_q   <= 32'd0;
      wdat_q  <= 32'd0;
      rdat_q  <= 32'd0;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end
  // Reset gates enable, strobe and acks combinationally so an interrupted access stops at once.
  assign bram_en  = !rst && state_q == ACCESS;
  assign bram_we  = (bram_en && cnt_q == 4'd0) ? we_q : 4'd0;
  assign bram_adr = adr_q;
  assign bram_di  = wdat_q;
  assign busy     = state_q != IDLE;
  assign grant    = grant_q;
  assign m0.ack   = !rst && state_q == ACK && !grant_q;
  assign m1.ack   = !rst && state_q == ACK && grant_q;
  assign m0.rdat  = rdat_q;
  assign m1.rdat  = rdat_q;
endmodule
